// File: rtl/spis_bus_pkg.sv
// Shared bus widths, register map and serialiser state encoding for the
// memory-mapped UART transmit port.
package spis_bus_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 8;

    localparam logic [3:0] OFS_TXDATA = 4'h0;
    localparam logic [3:0] OFS_STATUS = 4'h1;

    localparam int unsigned ST_FULL  = 0;
    localparam int unsigned ST_EMPTY = 1;
    localparam int unsigned ST_BUSY  = 2;
    localparam int unsigned ST_OVF   = 3;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_START = 2'd1,
        SER_DATA  = 2'd2,
        SER_STOP  = 2'd3
    } ser_state_t;

    // STATUS register image; field order matches the ST_* bit indices
    typedef struct packed {
        logic [3:0] rsvd;
        logic       ovf;
        logic       busy;
        logic       empty;
        logic       full;
    } status_t;

    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base);
        return addr[ADDR_W-1:4] == base[ADDR_W-1:4];
    endfunction

endpackage

// File: rtl/uart_tx_port_if.sv
// Link between the FIFO side of the port and the bit serialiser.
interface uart_tx_port_if;
    import spis_bus_pkg::*;

    logic              start_c;
    logic [DATA_W-1:0] tx_byte;
    logic              pop_c;
    logic              idle_c;

    modport master (output start_c, output tx_byte, input pop_c, input idle_c);
    modport slave  (input start_c, input tx_byte, output pop_c, output idle_c);

endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 serialiser: bit-time divider, shift register and frame FSM.
// Pops the next byte on the edge that launches its start bit.
module uart_tx_serializer
    import spis_bus_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic           clock,
    input  logic           resetN,
    uart_tx_port_if.slave  link,
    output logic           txd
);

    localparam int unsigned DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    ser_state_t        state, state_n;
    logic [DIV_W-1:0]  div, div_n;
    logic [BIT_W-1:0]  bit_idx, bit_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              txd_n;
    logic              pop_c;
    logic              bit_end_c;

    assign bit_end_c   = (div == DIV_LAST);
    assign link.pop_c  = pop_c;
    assign link.idle_c = (state == SER_IDLE);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state   <= SER_IDLE;
            div     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_n;
            div     <= div_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
            txd     <= txd_n;
        end
    end

    // Next-state: the divider restarts at every bit boundary and while idle
    always_comb begin
        state_n = state;
        bit_n   = bit_idx;
        shreg_n = shreg;
        txd_n   = txd;
        pop_c   = 1'b0;
        div_n   = (state == SER_IDLE || bit_end_c) ? '0 : div + DIV_W'(1);

        case (state)
            SER_IDLE: begin
                txd_n = 1'b1;
                if (link.start_c) begin
                    pop_c   = 1'b1;
                    shreg_n = link.tx_byte;
                    txd_n   = 1'b0;
                    state_n = SER_START;
                end
            end
            SER_START: begin
                if (bit_end_c) begin
                    state_n = SER_DATA;
                    bit_n   = '0;
                    txd_n   = shreg[0];
                    shreg_n = {1'b0, shreg[DATA_W-1:1]};
                end
            end
            SER_DATA: begin
                if (bit_end_c) begin
                    if (bit_idx == BIT_LAST) begin
                        state_n = SER_STOP;
                        txd_n   = 1'b1;
                    end else begin
                        bit_n   = bit_idx + BIT_W'(1);
                        txd_n   = shreg[0];
                        shreg_n = {1'b0, shreg[DATA_W-1:1]};
                    end
                end
            end
            SER_STOP: begin
                // Chain straight into the next start bit when more data waits
                if (bit_end_c) begin
                    if (link.start_c) begin
                        pop_c   = 1'b1;
                        shreg_n = link.tx_byte;
                        txd_n   = 1'b0;
                        state_n = SER_START;
                    end else begin
                        txd_n   = 1'b1;
                        state_n = SER_IDLE;
                    end
                end
            end
            default: begin
                txd_n   = 1'b1;
                state_n = SER_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: register decode, TX FIFO and STATUS.
// Stores are captured on the falling clock edge; the serialiser pops on the rising edge.
module uart_tx_port
    import spis_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 12'hFF0,
    parameter int unsigned       CLKS_PER_BIT = 16,
    parameter int unsigned       FIFO_DEPTH   = 4
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic [ADDR_W-1:0] addressBus,
    inout  wire  [DATA_W-1:0] dataBus,
    input  logic              write,
    output logic              txd,
    output logic              txBusy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              overflow;

    logic              in_win_c, wr_en_c, push_c, drop_c, clr_c;
    logic              empty_c, full_c;
    logic [3:0]        ofs_c;
    status_t           status_c;
    logic [DATA_W-1:0] rd_data_c;

    uart_tx_port_if link ();

    assign in_win_c = in_window(addressBus, BASE_ADDR);
    assign ofs_c    = addressBus[3:0];
    assign wr_en_c  = write && in_win_c;
    assign empty_c  = (wr_ptr == rd_ptr);
    assign full_c   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push_c   = wr_en_c && (ofs_c == OFS_TXDATA) && !full_c;
    assign drop_c   = wr_en_c && (ofs_c == OFS_TXDATA) && full_c;
    assign clr_c    = wr_en_c && (ofs_c == OFS_STATUS) && dataBus[ST_OVF];

    // Write side of the FIFO and the sticky overflow flag (set beats clear)
    always_ff @(negedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_c)
                wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            if (drop_c)
                overflow <= 1'b1;
            else if (clr_c)
                overflow <= 1'b0;
        end
    end

    always_ff @(negedge clock) begin
        if (push_c)
            fifo_mem[wr_ptr[PTR_W-1:0]] <= dataBus;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN)
            rd_ptr <= '0;
        else if (link.pop_c)
            rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
    end

    assign link.start_c = !empty_c;
    assign link.tx_byte = fifo_mem[rd_ptr[PTR_W-1:0]];

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clock  (clock),
        .resetN (resetN),
        .link   (link.slave),
        .txd    (txd)
    );

    assign txBusy = !link.idle_c || !empty_c;

    always_comb begin
        status_c       = '0;
        status_c.ovf   = overflow;
        status_c.busy  = txBusy;
        status_c.empty = empty_c;
        status_c.full  = full_c;
    end

    // Combinational read mux; every non-STATUS offset reads as zero
    always_comb begin
        rd_data_c = '0;
        if (ofs_c == OFS_STATUS)
            rd_data_c = status_c;
    end

    assign dataBus = (in_win_c && !write) ? rd_data_c : 'z;

endmodule

// File: tb/tb_uart_tx_port.sv
// Randomised self-checking bench for uart_tx_port against a queue-based frame model.
module tb_uart_tx_port;
    import spis_bus_pkg::*;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB;
    localparam logic [11:0] BASE  = 12'hFF0;

    logic        clock  = 1'b0;
    logic        resetN = 1'b0;
    logic [11:0] addressBus = 12'h000;
    logic        write  = 1'b0;
    logic [7:0]  drv    = 8'h00;
    logic        drv_en = 1'b0;
    wire  [7:0]  dataBus;
    logic        txd, txBusy;

    int checks   = 0;
    int failures = 0;

    assign dataBus = drv_en ? drv : 8'hzz;
    pullup (dataBus);

    always #5 clock = ~clock;

    uart_tx_port #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock      (clock),
        .resetN     (resetN),
        .addressBus (addressBus),
        .dataBus    (dataBus),
        .write      (write),
        .txd        (txd),
        .txBusy     (txBusy)
    );

    // Reference model: pending bytes queue plus position inside the current frame
    logic [7:0] mq[$];
    bit         m_ovf    = 1'b0;
    bit         m_active = 1'b0;
    int         m_t      = 0;
    logic [7:0] m_cur    = 8'h00;

    always @(posedge clock or negedge clock or negedge resetN) begin
        if (!resetN) begin
            mq.delete();
            m_ovf    = 1'b0;
            m_active = 1'b0;
            m_t      = 0;
        end else if (clock) begin
            if (m_active) begin
                m_t = m_t + 1;
                if (m_t == FRAME) m_active = 1'b0;
            end
            if (!m_active && mq.size() > 0) begin
                m_cur    = mq.pop_front();
                m_active = 1'b1;
                m_t      = 0;
            end
        end else if (write && addressBus[11:4] == BASE[11:4]) begin
            if (addressBus[3:0] == 4'h0) begin
                if (mq.size() < DEPTH) mq.push_back(drv);
                else m_ovf = 1'b1;
            end else if (addressBus[3:0] == 4'h1 && drv[3]) begin
                m_ovf = 1'b0;
            end
        end
    end

    function automatic logic exp_txd();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_t / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_cur[idx-1];
    endfunction

    function automatic logic exp_busy();
        return m_active || (mq.size() > 0);
    endfunction

    function automatic logic [7:0] exp_status();
        return {4'b0000, m_ovf, exp_busy(), mq.size() == 0, mq.size() == DEPTH};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of the serial line and busy flag
    always begin
        @(posedge clock);
        #3;
        check("txd_model", 8'(txd), 8'(exp_txd()));
        check("busy_model", 8'(txBusy), 8'(exp_busy()));
    end

    task automatic idle_bus();
        addressBus = 12'h000;
        write      = 1'b0;
        drv_en     = 1'b0;
    endtask

    task automatic store(input logic [11:0] a, input logic [7:0] d);
        @(posedge clock);
        #1;
        addressBus = a;
        write      = 1'b1;
        drv        = d;
        drv_en     = 1'b1;
    endtask

    task automatic end_store();
        @(posedge clock);
        #1;
        idle_bus();
    endtask

    task automatic load(input logic [11:0] a, input logic [7:0] exp, input string name);
        @(posedge clock);
        #1;
        addressBus = a;
        write      = 1'b0;
        drv_en     = 1'b0;
        #1;
        check(name, dataBus, exp);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (txBusy && n < budget) begin
            @(posedge clock);
            n = n + 1;
        end
        #2;
        check("drain_timeout", 8'(txBusy), 8'h00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        failures = failures + 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  fr;
        logic [11:0] a;
        int          op;

        // Reset and idle
        idle_bus();
        #23;
        check("rst_txd", 8'(txd), 8'h01);
        check("rst_busy", 8'(txBusy), 8'h00);
        @(posedge clock);
        #2;
        resetN = 1'b1;
        load(12'hFF1, 8'h02, "status_after_reset");
        load(12'h123, 8'hFF, "bus_released_out_of_window");
        idle_bus();

        // Single byte: exact bit sequence and busy duration
        fr = {1'b1, 8'hA5, 1'b0};
        store(12'hFF0, 8'hA5);
        @(posedge clock);
        #1;
        idle_bus();
        #2;
        for (int k = 0; k < int'(FRAME); k++) begin
            check("a5_bit", 8'(txd), 8'(fr[k / CPB]));
            check("a5_busy", 8'(txBusy), 8'h01);
            @(posedge clock);
            #3;
        end
        check("a5_idle_txd", 8'(txd), 8'h01);
        check("a5_busy_fall", 8'(txBusy), 8'h00);

        // Overflow: six back-to-back stores, one in flight, four queued, one dropped
        for (int i = 0; i < 6; i++) store(12'hFF0, 8'(8'h30 + i));
        end_store();
        load(12'hFF1, 8'h0D, "status_overflow");
        store(12'hFF1, 8'h08);
        end_store();
        load(12'hFF1, 8'h05, "status_ovf_cleared");
        idle_bus();
        wait_idle(400);

        // Back-to-back frames with no idle gap
        store(12'hFF0, 8'h00);
        store(12'hFF0, 8'hFF);
        end_store();
        repeat (38) @(posedge clock);
        #2;
        check("b2b_stop1", 8'(txd), 8'h01);
        @(posedge clock);
        #2;
        check("b2b_start2", 8'(txd), 8'h00);
        repeat (39) @(posedge clock);
        #2;
        check("b2b_stop2", 8'(txd), 8'h01);
        check("b2b_busy79", 8'(txBusy), 8'h01);
        @(posedge clock);
        #2;
        check("b2b_busy80", 8'(txBusy), 8'h00);

        // Reserved offsets and TXDATA read back as zero; reserved writes do nothing
        load(12'hFF5, 8'h00, "read_reserved");
        load(12'hFF0, 8'h00, "read_txdata");
        store(12'hFF7, 8'hFF);
        end_store();
        store(12'hFF1, 8'hF7);
        end_store();
        load(12'hFF1, 8'h02, "status_after_reserved_write");
        idle_bus();

        // Reset during data bit 3
        store(12'hFF0, 8'h00);
        end_store();
        repeat (16) @(posedge clock);
        #2;
        check("mid_frame_bit3", 8'(txd), 8'h00);
        resetN = 1'b0;
        #1;
        check("mid_reset_txd", 8'(txd), 8'h01);
        check("mid_reset_busy", 8'(txBusy), 8'h00);
        @(posedge clock);
        #2;
        resetN = 1'b1;
        load(12'hFF1, 8'h02, "status_after_mid_reset");
        idle_bus();
        repeat (50) @(posedge clock);
        #2;
        check("no_frame_after_reset", 8'(txd), 8'h01);

        // Randomised traffic against the model
        for (int it = 0; it < 160; it++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 4) begin
                repeat ($urandom_range(1, 3)) store(12'hFF0, 8'($urandom));
                end_store();
            end else if (op == 5) begin
                a = 12'($urandom_range(0, 12'hFEF));
                if ($urandom_range(0, 1) == 1) a = {8'hFF, 4'($urandom_range(2, 15))};
                store(a, 8'($urandom));
                end_store();
            end else if (op == 6) begin
                store(12'hFF1, 8'($urandom));
                end_store();
            end else if (op == 7) begin
                a = {8'hFF, 4'($urandom_range(0, 15))};
                load(a, (a[3:0] == 4'h1) ? exp_status() : 8'h00, "rand_read");
                idle_bus();
            end else if (op == 8) begin
                load(12'hFF1, exp_status(), "rand_status");
                idle_bus();
            end else begin
                repeat ($urandom_range(0, 40)) @(posedge clock);
            end
        end
        wait_idle(600);
        load(12'hFF1, exp_status(), "final_status");
        idle_bus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
